// File: rtl/dual_diagonal_backsub.sv
// dual_diagonal_backsub: streaming GF(2) back-substitution x[i] = x[i-1] ^ y[i], restarting every NUM_WORDS words.
module dual_diagonal_backsub #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  always_comb begin
    acc_d   = i_in_valid ? ((idx_q == '0) ? i_in_data : acc_q ^ i_in_data) : acc_q;
    idx_d   = !i_in_valid ? idx_q : (idx_q == IDX_W'(NUM_WORDS - 1)) ? '0 : idx_q + 1'b1;
    valid_d = i_in_valid;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idx_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end
  // The accumulator always equals the last emitted word, so it doubles as the output register.
  assign o_out_data  = acc_q;
  assign o_out_valid = valid_q;
endmodule

// File: tb/tb_dual_diagonal_backsub.sv
// tb_dual_diagonal_backsub: directed vectors with hand-computed expected words for dual_diagonal_backsub.
module tb_dual_diagonal_backsub;
  localparam int WIDTH = 16;
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  int               tests = 0;
  int               fails = 0;
  int               pulses = 0;
  logic [WIDTH-1:0] last_exp;
  logic [WIDTH-1:0] ref_in  [8] = '{16'd37449, 16'd56173, 16'd28086, 16'd46811,
                                    16'd56173, 16'd28086, 16'd46811, 16'd56173};
  logic [WIDTH-1:0] ref_out [8] = '{16'd37449, 16'd18724, 16'd9362, 16'd37449,
                                    16'd18724, 16'd9362, 16'd37449, 16'd18724};
  dual_diagonal_backsub #(.WIDTH(WIDTH), .NUM_WORDS(8)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .o_out_data (out_data),
    .o_out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d);
    rst      = 1'b0;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    check("valid", out_valid, v);
    check("data", out_data, exp_d);
    last_exp = exp_d;
  endtask
  task automatic send_ref();
    for (int i = 0; i < 8; i++) drive(1'b1, ref_in[i], ref_out[i]);
  endtask
  initial begin
    int p0;
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hffff;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    p0 = pulses;
    for (int i = 0; i < 120; i++) drive(1'b0, WIDTH'($urandom), 16'd0);
    check("idle_pulses", pulses - p0, 0);
    p0 = pulses;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'd0, 16'd0);
    drive(1'b0, 16'd0, 16'd0);
    check("zero_count", pulses - p0, 8);
    p0 = pulses;
    send_ref();
    drive(1'b0, 16'd0, ref_out[7]);
    check("ref_count", pulses - p0, 8);
    p0 = pulses;
    send_ref();
    send_ref();
    drive(1'b0, 16'd0, ref_out[7]);
    check("b2b_count", pulses - p0, 16);
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(1'b0, WIDTH'($urandom), last_exp);
      drive(1'b1, ref_in[i], ref_out[i]);
    end
    drive(1'b0, 16'd0, ref_out[7]);
    check("gap_count", pulses - p0, 8);
    for (int i = 0; i < 3; i++) drive(1'b1, ref_in[i], ref_out[i]);
    rst = 1'b1; in_valid = 1'b1; in_data = ref_in[3];
    @(posedge clk);
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    p0 = pulses;
    send_ref();
    drive(1'b0, 16'd0, ref_out[7]);
    check("midrst_count", pulses - p0, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
